// File: rtl/state_machine.sv
// Run-length classifier: counts consecutive high samples of in_i, saturating at LONG,
// and marks the end of each run with a one-cycle short-end or long-end code.
module state_machine (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       in_i,
  output logic [2:0] out_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    H1      = 3'b001,
    H2      = 3'b010,
    H3      = 3'b011,
    LONG    = 3'b100,
    END_S   = 3'b101,
    END_L   = 3'b110,
    ILLEGAL = 3'b111
  } state_t;

  state_t state;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:         state <= in_i ? H1   : IDLE;
        H1:           state <= in_i ? H2   : END_S;
        H2:           state <= in_i ? H3   : END_S;
        H3:           state <= in_i ? LONG : END_S;
        LONG:         state <= in_i ? LONG : END_L;
        END_S, END_L: state <= in_i ? H1   : IDLE;
        // the unused code recovers to IDLE whatever the input
        default:      state <= IDLE;
      endcase
    end
  end

  // Moore output: the state register drives the port directly
  assign out_o = state;

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: drives on the falling edge, checks one time unit
// after each rising edge, and also checks that out_o holds steady into the next falling edge.
module tb_state_machine;

  logic       clk_i;
  logic       reset_i;
  logic       in_i;
  logic [2:0] out_o;

  int vectors;
  int miscompares;
  logic       have_prev;
  logic [2:0] prev_expected;

  state_machine dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .in_i    (in_i),
    .out_o   (out_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // one clock edge: confirm the previous output is still held, drive, then check the new output
  task automatic step(input string tag, input logic rst, input logic din, input logic [2:0] expected);
    @(negedge clk_i);
    if (have_prev) begin
      vectors++;
      assert (out_o === prev_expected)
        else begin
          miscompares++;
          $error("[TB] FAIL %s_hold: out_o observed %b, expected %b", tag, out_o, prev_expected);
        end
    end
    reset_i = rst;
    in_i    = din;
    @(posedge clk_i);
    #1;
    vectors++;
    assert (out_o === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: out_o observed %b, expected %b", tag, out_o, expected);
      end
    prev_expected = expected;
    have_prev     = 1'b1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    have_prev     = 1'b0;
    prev_expected = 3'b000;
    reset_i       = 1'b1;
    in_i          = 1'b0;

    // reset hold, then release with the input low
    step("rst_hold0", 1'b1, 1'b0, 3'b000);
    step("rst_hold1", 1'b1, 1'b0, 3'b000);
    step("rst_rel0",  1'b0, 1'b0, 3'b000);
    step("rst_rel1",  1'b0, 1'b0, 3'b000);
    step("rst_rel2",  1'b0, 1'b0, 3'b000);
    step("rst_rel3",  1'b0, 1'b0, 3'b000);

    // long run ending in END_L, then reset
    step("long_h1",   1'b0, 1'b1, 3'b001);
    step("long_h2",   1'b0, 1'b1, 3'b010);
    step("long_h3",   1'b0, 1'b1, 3'b011);
    step("long_long", 1'b0, 1'b1, 3'b100);
    step("long_endl", 1'b0, 1'b0, 3'b110);
    step("long_rst",  1'b1, 1'b0, 3'b000);

    // short run
    step("short_h1",   1'b0, 1'b1, 3'b001);
    step("short_h2",   1'b0, 1'b1, 3'b010);
    step("short_ends", 1'b0, 1'b0, 3'b101);
    step("short_idle", 1'b0, 1'b0, 3'b000);

    // saturation: ten high samples hold LONG for seven cycles
    step("sat_h1", 1'b0, 1'b1, 3'b001);
    step("sat_h2", 1'b0, 1'b1, 3'b010);
    step("sat_h3", 1'b0, 1'b1, 3'b011);
    for (int i = 0; i < 7; i++)
      step($sformatf("sat_long%0d", i), 1'b0, 1'b1, 3'b100);
    step("sat_endl", 1'b0, 1'b0, 3'b110);
    step("sat_idle", 1'b0, 1'b0, 3'b000);

    // back-to-back runs through END_S -> H1
    step("b2b_h1a",  1'b0, 1'b1, 3'b001);
    step("b2b_ends", 1'b0, 1'b0, 3'b101);
    step("b2b_h1b",  1'b0, 1'b1, 3'b001);
    step("b2b_h2",   1'b0, 1'b1, 3'b010);
    step("b2b_end2", 1'b0, 1'b0, 3'b101);
    step("b2b_idle", 1'b0, 1'b0, 3'b000);

    // END_L -> H1 restart, then a short run
    step("lr_h1",   1'b0, 1'b1, 3'b001);
    step("lr_h2",   1'b0, 1'b1, 3'b010);
    step("lr_h3",   1'b0, 1'b1, 3'b011);
    step("lr_long", 1'b0, 1'b1, 3'b100);
    step("lr_endl", 1'b0, 1'b0, 3'b110);
    step("lr_new",  1'b0, 1'b1, 3'b001);
    step("lr_ends", 1'b0, 1'b0, 3'b101);
    step("lr_idle", 1'b0, 1'b0, 3'b000);

    // reset in LONG with the input still high: no END_L afterwards
    step("mid_h1",    1'b0, 1'b1, 3'b001);
    step("mid_h2",    1'b0, 1'b1, 3'b010);
    step("mid_h3",    1'b0, 1'b1, 3'b011);
    step("mid_long0", 1'b0, 1'b1, 3'b100);
    step("mid_long1", 1'b0, 1'b1, 3'b100);
    step("mid_rst",   1'b1, 1'b1, 3'b000);
    step("mid_rel",   1'b0, 1'b0, 3'b000);

    // reset while in H2 with the input high
    step("h2r_h1",  1'b0, 1'b1, 3'b001);
    step("h2r_h2",  1'b0, 1'b1, 3'b010);
    step("h2r_rst", 1'b1, 1'b1, 3'b000);
    step("h2r_go",  1'b0, 1'b1, 3'b001);
    step("h2r_end", 1'b0, 1'b0, 3'b101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
